// File: rtl/mem_fetch_unit.sv
// Memory-side stage of the multicycle MIPS core: owns IR/MDR and runs each access over a req/ack port.
// Optional misaligned-access trap is enabled by defining MFU_ALIGN_CHECK_EN.
module mem_fetch_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iord,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] aluout,
   input  logic [DATA_W-1:0] wdata,
   input  logic              IRWrite,
   input  logic              MemRead,
   input  logic              MemWrite,
   output logic              stall,
   output logic [DATA_W-1:0] instr,
   output logic [5:0]        op,
   output logic [5:0]        funct,
   output logic [DATA_W-1:0] mdr,
   output logic              err,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              fetch_q, fetch_d;
   logic              load_q, load_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              err_q, err_d;

   logic              start;
   logic [ADDR_W-1:0] sel_addr;
   logic              misalign;

   assign start    = IRWrite | MemRead | MemWrite;
   assign sel_addr = iord ? aluout : pc;

`ifdef MFU_ALIGN_CHECK_EN
   assign misalign = (sel_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      fetch_d = fetch_q;
      load_d  = load_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ir_d    = ir_q;
      mdr_d   = mdr_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (misalign) begin
                  // Trapped access skips the memory entirely and reports via err in DONE
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_REQ;
                  fetch_d = IRWrite;
                  load_d  = ~IRWrite & MemRead;
                  we_d    = ~IRWrite & ~MemRead & MemWrite;
                  addr_d  = sel_addr;
                  wdata_d = wdata;
               end
            end
         end
         S_REQ: begin
            if (m_ack) begin
               if (fetch_q) begin
                  ir_d = m_rdata;
               end else if (load_q) begin
                  mdr_d = m_rdata;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         fetch_q <= 1'b0;
         load_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ir_q    <= '0;
         mdr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fetch_q <= fetch_d;
         load_q  <= load_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         err_q   <= err_d;
      end
   end

   // In IDLE the controller must hold in the same cycle it asks, hence the combinational path
   assign stall   = (state_q == S_IDLE) ? start : (state_q == S_REQ);
   assign m_req   = (state_q == S_REQ);
   assign m_we    = we_q & m_req;
   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   assign instr   = ir_q;
   assign op      = ir_q[31:26];
   assign funct   = ir_q[5:0];
   assign mdr     = mdr_q;
   assign err     = err_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Scoreboard bench for mem_fetch_unit: random controller traffic against a memory responder and a reference model.
`timescale 1ns/1ps
module tb_mem_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        iord = 1'b0;
   logic [31:0] pc = '0, aluout = '0, wdata = '0;
   logic        IRWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
   logic        stall, err, m_req, m_we;
   logic [31:0] instr, mdr, m_addr, m_wdata;
   logic [5:0]  op, funct;
   logic        m_ack = 1'b0;
   logic [31:0] m_rdata = '0;

   mem_fetch_unit #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .iord(iord), .pc(pc), .aluout(aluout), .wdata(wdata),
      .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .stall(stall), .instr(instr), .op(op), .funct(funct), .mdr(mdr), .err(err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          waits;
   } req_t;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] mdr;
      logic        err;
      int          stall_cycles;
   } res_t;

   req_t req_q[$];
   res_t res_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   sb_en  = 1'b0;

   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] dut_mem [logic [31:0]];
   logic [31:0] ref_ir  = '0;
   logic [31:0] ref_mdr = '0;

   function automatic logic [31:0] init_word(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
   endfunction

   function automatic logic [31:0] ref_read(logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] dut_read(logic [31:0] a);
      return dut_mem.exists(a) ? dut_mem[a] : init_word(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic summary_and_fatal(input string why);
      errors++;
      $display("FAIL %s", why);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "bench aborted");
   endtask

   // Monitor: a completed access is the first non-stall cycle after a stall run
   initial begin : monitor
      int   st_cnt;
      res_t r;
      st_cnt = 0;
      forever begin
         @(negedge clk);
         if (!reset || !sb_en) begin
            st_cnt = 0;
         end else if (stall) begin
            st_cnt++;
         end else if (st_cnt > 0) begin
            if (res_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_unexpected: got completion expected none");
            end else begin
               r = res_q.pop_front();
               check("instr", instr, r.ir);
               check("op", {26'd0, op}, {26'd0, r.ir[31:26]});
               check("funct", {26'd0, funct}, {26'd0, r.ir[5:0]});
               check("mdr", mdr, r.mdr);
               check("err", {31'd0, err}, {31'd0, r.err});
               check("stall_cycles", st_cnt, r.stall_cycles);
               $display("done: stall=%0d instr=0x%08h mdr=0x%08h err=%0d", st_cnt, instr, mdr, err);
            end
            st_cnt = 0;
         end
      end
   end

   // Memory responder: checks the request and acks after the scripted wait count
   initial begin : responder
      req_t q;
      forever begin
         @(negedge clk);
         if (sb_en && reset && m_req) begin
            if (req_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL req_unexpected: got m_req addr 0x%08h expected none", m_addr);
               @(negedge clk);
            end else begin
               q = req_q.pop_front();
               check("m_addr", m_addr, q.addr);
               check("m_we", {31'd0, m_we}, {31'd0, q.we});
               if (q.we) check("m_wdata", m_wdata, q.wdata);
               for (int i = 0; i < q.waits; i++) begin
                  @(negedge clk);
                  check("m_req_hold", {31'd0, m_req}, 32'd1);
                  check("m_addr_hold", m_addr, q.addr);
               end
               m_ack = 1'b1;
               if (m_we) begin
                  dut_mem[m_addr] = m_wdata;
                  m_rdata = $urandom;
               end else begin
                  m_rdata = dut_read(m_addr);
               end
               @(posedge clk);
               #1;
               m_ack   = 1'b0;
               m_rdata = $urandom;
               @(negedge clk);
               check("m_req_fall", {31'd0, m_req}, 32'd0);
            end
         end
      end
   end

   // kind: 0 fetch, 1 load, 2 store, 3 illegal fetch+store (behaves as fetch)
   task automatic do_access(input int kind, input logic [31:0] addr, input logic [31:0] wd, input int waits);
      req_t q;
      res_t r;
      logic mis;
      int   guard;
      mis = 1'b0;
`ifdef MFU_ALIGN_CHECK_EN
      mis = (addr[1:0] != 2'b00);
`endif
      r.err = mis;
      if (mis) begin
         r.stall_cycles = 1;
      end else begin
         q.addr  = addr;
         q.we    = (kind == 2);
         q.wdata = wd;
         q.waits = waits;
         req_q.push_back(q);
         r.stall_cycles = waits + 2;
         if (kind == 0 || kind == 3) ref_ir = ref_read(addr);
         else if (kind == 1)         ref_mdr = ref_read(addr);
         else                        ref_mem[addr] = wd;
      end
      r.ir  = ref_ir;
      r.mdr = ref_mdr;
      res_q.push_back(r);
      $display("issue: kind=%0d addr=0x%08h wdata=0x%08h waits=%0d", kind, addr, wd, waits);

      IRWrite  = (kind == 0 || kind == 3);
      MemRead  = (kind == 1) || (kind == 0 && $urandom_range(0, 1) == 1);
      MemWrite = (kind == 2) || (kind == 3) || (kind == 1 && $urandom_range(0, 1) == 1);
      iord     = $urandom_range(0, 1) == 1;
      pc       = iord ? $urandom : addr;
      aluout   = iord ? addr : $urandom;
      wdata    = wd;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (stall && guard < 200);
      if (guard >= 200) summary_and_fatal("access_timeout: stall never dropped");
      @(posedge clk);
      #1;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
   endtask

   initial begin : main
      logic [31:0] a;
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_instr", instr, 32'd0);
      check("rst_mdr", mdr, 32'd0);
      check("rst_m_req", {31'd0, m_req}, 32'd0);
      check("rst_m_we", {31'd0, m_we}, 32'd0);
      check("rst_m_addr", m_addr, 32'd0);
      check("rst_m_wdata", m_wdata, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb_en = 1'b1;

      ref_mem[32'h40]  = 32'h0231_8020;
      dut_mem[32'h40]  = 32'h0231_8020;
      ref_mem[32'h100] = 32'hDEAD_BEEF;
      dut_mem[32'h100] = 32'hDEAD_BEEF;

      do_access(0, 32'h40, 32'h0, 0);
      do_access(1, 32'h100, 32'h0, 3);
      do_access(2, 32'h200, 32'h1234_5678, 2);
      do_access(0, 32'h200, 32'h0, 0);
      do_access(1, 32'h102, 32'h0, 0);
      do_access(3, 32'h40, 32'hFFFF_0000, 1);

      for (int n = 0; n < 60; n++) begin
         a = $urandom_range(0, 15) << 2;
         if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
         do_access($urandom_range(0, 3), a, $urandom, $urandom_range(0, 4));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      do_access(0, 32'h100, 32'h0, 0);

      // Directed: ack while idle must not disturb IR/MDR
      sb_en = 1'b0;
      @(posedge clk);
      #1;
      m_ack   = 1'b1;
      m_rdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      m_ack = 1'b0;
      @(negedge clk);
      check("spur_instr", instr, ref_ir);
      check("spur_mdr", mdr, ref_mdr);
      check("spur_m_req", {31'd0, m_req}, 32'd0);
      $display("spurious ack: instr=0x%08h mdr=0x%08h", instr, mdr);

      // Directed: reset two cycles into REQ, then a stray ack
      @(posedge clk);
      #1;
      IRWrite = 1'b1;
      iord    = 1'b0;
      pc      = 32'h80;
      repeat (2) @(posedge clk);
      #1;
      check("midreq_m_req", {31'd0, m_req}, 32'd1);
      reset   = 1'b0;
      IRWrite = 1'b0;
      #1;
      check("midreq_rst_m_req", {31'd0, m_req}, 32'd0);
      check("midreq_rst_instr", instr, 32'd0);
      check("midreq_rst_mdr", mdr, 32'd0);
      check("midreq_rst_stall", {31'd0, stall}, 32'd0);
      check("midreq_rst_m_addr", m_addr, 32'd0);
      @(posedge clk);
      #1;
      reset   = 1'b1;
      m_ack   = 1'b1;
      m_rdata = 32'hAAAA_5555;
      @(posedge clk);
      #1;
      m_ack = 1'b0;
      @(negedge clk);
      check("stray_instr", instr, 32'd0);
      check("stray_m_req", {31'd0, m_req}, 32'd0);
      check("stray_stall", {31'd0, stall}, 32'd0);
      $display("reset mid-REQ: instr=0x%08h m_req=%0d", instr, m_req);

      check("leftover_req_q", req_q.size(), 32'd0);
      check("leftover_res_q", res_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      summary_and_fatal("watchdog: simulation time limit reached");
   end

endmodule
